// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared AHB types for the slave-side arbiter: transfer/burst encodings,
// arbiter FSM states and burst-length helpers.
package AHB_package;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_type;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'd0,
      HB_INCR   = 3'd1,
      HB_WRAP4  = 3'd2,
      HB_INCR4  = 3'd3,
      HB_WRAP8  = 3'd4,
      HB_INCR8  = 3'd5,
      HB_WRAP16 = 3'd6,
      HB_INCR16 = 3'd7
   } hburst_type;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BURST  = 2'd1,
      ST_LOCKED = 2'd2
   } arb_state_t;

   // Undefined-length and single transfers report one beat.
   function automatic int burst_beats(hburst_type b);
      unique case (b)
         HB_WRAP4, HB_INCR4:   return 4;
         HB_WRAP8, HB_INCR8:   return 8;
         HB_WRAP16, HB_INCR16: return 16;
         default:              return 1;
      endcase
   endfunction

   function automatic logic is_fixed_burst(hburst_type b);
      return burst_beats(b) > 1;
   endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// Bus bundle between the masters' request side and the slave arbiter.
// The slave modport is the arbiter's view.
interface ahb_slave_arbiter_if
   import AHB_package::*;
#(
   parameter int MASTER_NUM      = 4,
   parameter int MASTER_ID_WIDTH = $clog2(MASTER_NUM)
);
   logic [MASTER_NUM-1:0]      hreq;
   logic [MASTER_NUM-1:0]      hlock;
   htrans_type                 htrans;
   hburst_type                 hburst;
   logic                       hready;
   logic [MASTER_NUM-1:0]      hgrant;
   logic [MASTER_ID_WIDTH-1:0] hmaster_addr;
   logic [MASTER_ID_WIDTH-1:0] hmaster_data;
   logic                       hmastlock;

   modport slave (
      input  hreq, hlock, htrans, hburst, hready,
      output hgrant, hmaster_addr, hmaster_data, hmastlock
   );

   modport master (
      output hreq, hlock, htrans, hburst, hready,
      input  hgrant, hmaster_addr, hmaster_data, hmastlock
   );
endinterface

// File: rtl/ahb_slave_arbiter_rr_picker.sv
// Round-robin picker: first requester after ptr, wrapping, ptr itself last.
// Purely combinational.
module ahb_rr_picker #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [ID_W-1:0] winner,
   output logic            valid
);
   logic [ID_W-1:0] idx;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 1; i <= N; i++) begin
         idx = ID_W'((int'(ptr) + i) % N);
         if (!valid && req[idx]) begin
            valid  = 1'b1;
            winner = idx;
         end
      end
   end
endmodule

// File: rtl/ahb_slave_arbiter.sv
// Slave-side AHB arbiter: round-robin grant with fixed-burst, INCR and
// locked-sequence ownership; hready low freezes everything.
module ahb_slave_arbiter
   import AHB_package::*;
#(
   parameter int MASTER_NUM      = 4,
   parameter int MASTER_ID_WIDTH = $clog2(MASTER_NUM),
   parameter int MAX_BEAT_WIDTH  = 4
) (
   input  logic                hclk,
   input  logic                hreset,
   ahb_slave_arbiter_if.slave  bus
);
   arb_state_t                 state_q, state_d;
   logic [MAX_BEAT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [MASTER_ID_WIDTH-1:0] addr_q, addr_d, data_q;
   logic [MASTER_ID_WIDTH-1:0] win;
   logic                       win_v;
   logic                       handover;
   logic                       is_seq;

   // The owner is always the last winner, so it doubles as the rr pointer.
   ahb_rr_picker #(
      .N    (MASTER_NUM),
      .ID_W (MASTER_ID_WIDTH)
   ) u_pick (
      .req    (bus.hreq),
      .ptr    (addr_q),
      .winner (win),
      .valid  (win_v)
   );

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (bus.hready) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= addr_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      handover = 1'b0;
      is_seq   = (bus.htrans == HT_SEQ);
      unique case (state_q)
         ST_IDLE: handover = 1'b1;
         ST_BURST: begin
            if (bus.htrans == HT_IDLE) begin
               handover = 1'b1;
            end else begin
               if (is_seq) cnt_d = cnt_q - 1'b1;
               // Hand over on the edge that completes the last beat.
               if (cnt_q == '0 ||
                   (is_seq && cnt_q == MAX_BEAT_WIDTH'(1)))
                  handover = 1'b1;
            end
         end
         ST_LOCKED: handover = !bus.hlock[addr_q];
         default: handover = 1'b1;
      endcase

      if (handover) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         if (bus.hlock[addr_q]) begin
            state_d = ST_LOCKED;
         end else if (bus.htrans == HT_NONSEQ &&
                      is_fixed_burst(bus.hburst)) begin
            state_d = ST_BURST;
            cnt_d   = MAX_BEAT_WIDTH'(burst_beats(bus.hburst) - 1);
         end else if (bus.hburst == HB_INCR && bus.hreq[addr_q] &&
                      (is_seq || bus.htrans == HT_BUSY)) begin
            addr_d = addr_q;
         end else if (win_v) begin
            addr_d = win;
         end
      end
   end

   assign bus.hgrant       = MASTER_NUM'(1) << addr_q;
   assign bus.hmaster_addr = addr_q;
   assign bus.hmaster_data = data_q;
   assign bus.hmastlock    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter: vector table, directed burst/lock/reset
// sequences, then random traffic against a transaction-level model.
module tb_ahb_slave_arbiter;
   import AHB_package::*;

   logic hclk = 1'b0;
   logic hreset;
   int   tests = 0;
   int   fails = 0;

   ahb_slave_arbiter_if #(.MASTER_NUM(4), .MASTER_ID_WIDTH(2)) bus ();

   ahb_slave_arbiter #(
      .MASTER_NUM      (4),
      .MASTER_ID_WIDTH (2),
      .MAX_BEAT_WIDTH  (4)
   ) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .bus    (bus)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic [3:0] req;
      htrans_type tr;
      logic       rdy;
      int         e_addr;
      int         e_data;
   } vec_t;

   vec_t tbl[13];

   // transaction-level model state
   int m_owner, m_data, m_left;
   bit m_locked;

   task automatic check(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(logic [3:0] req, logic [3:0] lock,
                        htrans_type tr, hburst_type hb, logic rdy);
      bus.hreq   = req;
      bus.hlock  = lock;
      bus.htrans = tr;
      bus.hburst = hb;
      bus.hready = rdy;
   endtask

   task automatic do_reset();
      drive(4'b0000, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1);
      hreset = 1'b1;
      step();
      hreset = 1'b0;
   endtask

   task automatic check_grant(string name, int owner);
      check({name, "_grant"}, int'(bus.hgrant), 1 << owner);
      check({name, "_addr"}, int'(bus.hmaster_addr), owner);
   endtask

   function automatic int beats_of(hburst_type b);
      int tbl_b[8] = '{1, 1, 4, 4, 8, 8, 16, 16};
      return tbl_b[int'(b)];
   endfunction

   // One completed address phase of the model.
   task automatic model_edge(logic [3:0] req, logic [3:0] lock,
                             htrans_type tr, hburst_type hb);
      bit free;
      int prev;
      prev = m_owner;
      free = 1'b1;
      if (m_locked) begin
         free = !lock[m_owner];
      end else if (m_left > 0) begin
         if (tr == HT_IDLE) m_left = 0;
         else if (tr == HT_SEQ) m_left--;
         free = (m_left == 0);
      end
      if (free) begin
         m_locked = 1'b0;
         m_left   = 0;
         if (lock[m_owner]) begin
            m_locked = 1'b1;
         end else if (tr == HT_NONSEQ && beats_of(hb) > 1) begin
            m_left = beats_of(hb) - 1;
         end else if (!(hb == HB_INCR && req[m_owner] &&
                        (tr == HT_SEQ || tr == HT_BUSY))) begin
            for (int off = 1; off <= 4; off++) begin
               if (req[(prev + off) % 4]) begin
                  m_owner = (prev + off) % 4;
                  break;
               end
            end
         end
      end
      m_data = prev;
   endtask

   initial begin
      logic [3:0] rq, lk;
      htrans_type rtr;
      hburst_type rhb;
      logic       rrdy, rrst;

      tbl[0]  = '{4'b1111, HT_NONSEQ, 1'b1, 1, 0};
      tbl[1]  = '{4'b1111, HT_NONSEQ, 1'b1, 2, 1};
      tbl[2]  = '{4'b1111, HT_NONSEQ, 1'b0, 2, 1};
      tbl[3]  = '{4'b1111, HT_NONSEQ, 1'b0, 2, 1};
      tbl[4]  = '{4'b1111, HT_NONSEQ, 1'b1, 3, 2};
      tbl[5]  = '{4'b1111, HT_NONSEQ, 1'b1, 0, 3};
      tbl[6]  = '{4'b1111, HT_NONSEQ, 1'b1, 1, 0};
      tbl[7]  = '{4'b0000, HT_IDLE,   1'b1, 1, 1};
      tbl[8]  = '{4'b0000, HT_IDLE,   1'b1, 1, 1};
      tbl[9]  = '{4'b0001, HT_IDLE,   1'b1, 0, 1};
      tbl[10] = '{4'b1001, HT_IDLE,   1'b1, 3, 0};
      tbl[11] = '{4'b1001, HT_IDLE,   1'b1, 0, 3};
      tbl[12] = '{4'b0001, HT_IDLE,   1'b1, 0, 0};

      hreset = 1'b0;
      do_reset();
      check_grant("reset", 0);
      check("reset_data", int'(bus.hmaster_data), 0);
      check("reset_mastlock", int'(bus.hmastlock), 0);

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].req, 4'b0000, tbl[i].tr, HB_SINGLE, tbl[i].rdy);
         step();
         check_grant($sformatf("vec%0d", i), tbl[i].e_addr);
         check($sformatf("vec%0d_data", i),
               int'(bus.hmaster_data), tbl[i].e_data);
      end

      // INCR8 by master 2 holds the grant for exactly 8 phases.
      do_reset();
      drive(4'b0100, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1);
      step();
      for (int p = 0; p < 8; p++) begin
         check_grant($sformatf("incr8_p%0d", p), 2);
         drive(4'b1111, 4'b0000, p == 0 ? HT_NONSEQ : HT_SEQ,
               HB_INCR8, 1'b1);
         step();
      end
      check_grant("incr8_after", 3);

      // INCR4 stalled for 3 cycles on beat 2.
      do_reset();
      drive(4'b0100, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1);
      step();
      drive(4'b1111, 4'b0000, HT_NONSEQ, HB_INCR4, 1'b1);
      step();
      for (int w = 0; w < 3; w++) begin
         drive(4'b1111, 4'b0000, HT_SEQ, HB_INCR4, 1'b0);
         step();
         check_grant($sformatf("stall%0d", w), 2);
         check($sformatf("stall%0d_data", w), int'(bus.hmaster_data), 2);
      end
      drive(4'b1111, 4'b0000, HT_SEQ, HB_INCR4, 1'b1);
      step();
      step();
      check_grant("incr4_beat4", 2);
      step();
      check_grant("incr4_after", 3);

      // Locked sequence by master 1; master 3's hlock gives no priority.
      do_reset();
      drive(4'b1111, 4'b1000, HT_NONSEQ, HB_SINGLE, 1'b1);
      step();
      check_grant("lock_win", 1);
      for (int t = 0; t < 5; t++) begin
         drive(4'b1111, 4'b1010, HT_NONSEQ, HB_SINGLE, t != 2);
         step();
         check_grant($sformatf("lock_t%0d", t), 1);
         check($sformatf("lock_t%0d_ml", t), int'(bus.hmastlock), 1);
      end
      drive(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE, 1'b0);
      step();
      check_grant("lock_hold", 1);
      check("lock_hold_ml", int'(bus.hmastlock), 1);
      drive(4'b1111, 4'b0000, HT_NONSEQ, HB_SINGLE, 1'b1);
      step();
      check_grant("lock_release", 2);
      check("lock_release_ml", int'(bus.hmastlock), 0);

      // Reset on beat 5 of INCR16.
      do_reset();
      drive(4'b0100, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1);
      step();
      drive(4'b1111, 4'b0000, HT_NONSEQ, HB_INCR16, 1'b1);
      step();
      for (int b = 0; b < 3; b++) begin
         drive(4'b1111, 4'b0000, HT_SEQ, HB_INCR16, 1'b1);
         step();
      end
      check_grant("incr16_b5", 2);
      hreset = 1'b1;
      step();
      hreset = 1'b0;
      check_grant("incr16_rst", 0);
      check("incr16_rst_data", int'(bus.hmaster_data), 0);
      check("incr16_rst_ml", int'(bus.hmastlock), 0);
      check("incr16_rst_fsm", int'(dut.state_q), int'(ST_IDLE));

      // WRAP8 cut short by IDLE on beat 2.
      drive(4'b0100, 4'b0000, HT_IDLE, HB_SINGLE, 1'b1);
      step();
      drive(4'b1111, 4'b0000, HT_NONSEQ, HB_WRAP8, 1'b1);
      step();
      drive(4'b1111, 4'b0000, HT_IDLE, HB_WRAP8, 1'b1);
      step();
      check_grant("wrap8_cut", 3);
      check("wrap8_cut_fsm", int'(dut.state_q), int'(ST_IDLE));

      // Random traffic against the model.
      do_reset();
      m_owner  = 0;
      m_data   = 0;
      m_left   = 0;
      m_locked = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rq   = 4'($urandom);
         lk   = 4'b0000;
         for (int k = 0; k < 4; k++) lk[k] = ($urandom_range(0, 9) == 0);
         rtr  = htrans_type'($urandom_range(0, 3));
         rhb  = hburst_type'($urandom_range(0, 7));
         rrdy = ($urandom_range(0, 3) != 0);
         rrst = ($urandom_range(0, 299) == 0);
         drive(rq, lk, rtr, rhb, rrdy);
         hreset = rrst;
         if (rrst) begin
            m_owner  = 0;
            m_data   = 0;
            m_left   = 0;
            m_locked = 1'b0;
         end else if (rrdy) begin
            model_edge(rq, lk, rtr, rhb);
         end
         step();
         hreset = 1'b0;
         check_grant("rnd", m_owner);
         check("rnd_data", int'(bus.hmaster_data), m_data);
         check("rnd_ml", int'(bus.hmastlock), int'(m_locked));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ahb_slave_arbiter.md
AHB_SLAVE_ARBITER -- requirements
Module: ahb_slave_arbiter

Interface
REQ-001 Parameter MASTER_NUM, default 4: number of masters competing for this slave (2..16).
REQ-002 Parameter MASTER_ID_WIDTH, default $clog2(MASTER_NUM): width of master index outputs.
REQ-003 Parameter MAX_BEAT_WIDTH, default 4: width of the burst beat counter (supports up to 16 beats).
REQ-004 Port hclk  input  1  rising-edge clock for all state.
REQ-005 Port hreset  input  1  synchronous, active-high reset, sampled on hclk.
REQ-006 Port hreq  input  MASTER_NUM  per-master request; bit i comes from master i's address decoder hreq for this slave.
REQ-007 Port hlock  input  MASTER_NUM  per-master locked-transfer request.
REQ-008 Port htrans  input  htrans_type  transfer type of the currently granted master (externally muxed by hmaster_addr).
REQ-009 Port hburst  input  hburst_type  burst type of the currently granted master.
REQ-010 Port hready  input  1  slave hreadyout; an address phase completes when high.
REQ-011 Port hgrant  output  MASTER_NUM  one-hot grant, address-phase owner.
REQ-012 Port hmaster_addr  output  MASTER_ID_WIDTH  index of the address-phase owner.
REQ-013 Port hmaster_data  output  MASTER_ID_WIDTH  index of the data-phase owner.
REQ-014 Port hmastlock  output  1  current address phase is a locked sequence.

Function
REQ-015 hgrant SHALL always be exactly one-hot and equal to 1<<hmaster_addr.
REQ-016 Arbitration SHALL be round-robin; the search starts at (last winner + 1) mod MASTER_NUM.
REQ-017 Re-arbitration SHALL occur only on a hclk edge where hready=1 and the FSM permits handover; the new grant is visible the next cycle (1-cycle latency).
REQ-018 FSM states: IDLE (no transfer owned), BURST (fixed-length burst in progress), LOCKED (hlock held by owner).
REQ-019 IDLE -> BURST: hready=1, htrans=NONSEQ, hburst in {INCR4, WRAP4, INCR8, WRAP8, INCR16, WRAP16}; beat counter loads beats-1 (3/7/15).
REQ-020 In BURST, the counter SHALL decrement on hready=1 with htrans=SEQ; BUSY holds the counter; return to IDLE when the counter is 0 and hready=1.
REQ-021 In BURST, grant SHALL NOT change unless the owner drives htrans=IDLE with hready=1 (early termination), which returns to IDLE.
REQ-022 SINGLE and INCR (undefined length) SHALL NOT enter BURST; INCR keeps the grant while the owner's hreq=1 and htrans is SEQ or BUSY.
REQ-023 Owner hlock=1 at a permitted handover SHALL enter LOCKED; assert hmastlock; hold the grant until hlock=0 and hready=1, then go to IDLE.
REQ-024 When no hreq bit is set, the grant SHALL park on the current owner (no change).
REQ-025 hmaster_data SHALL load hmaster_addr on every hclk edge with hready=1 and hold otherwise.
REQ-026 Simultaneous requests SHALL resolve by the round-robin pointer only; hlock gives no priority to a non-owner.
REQ-027 Owner hreq deasserting mid-BURST SHALL NOT cut the burst; the counter governs.
REQ-028 hready=0 SHALL freeze all state (grant, counter, FSM, hmaster_data).

Reset
REQ-029 With hreset=1 at a hclk edge: FSM=IDLE, counter=0, hmaster_addr=0, hmaster_data=0, hgrant=1 (master 0), hmastlock=0, round-robin pointer=0.
REQ-030 Reset SHALL take precedence over every other event, including mid-burst and LOCKED; no transfer state survives it.

Structure
REQ-031 hburst_type (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16) and the arbiter FSM state enum SHALL live in AHB_package beside htrans_type.
REQ-032 Round-robin selection SHALL be a combinational sub-module ahb_rr_picker (inputs: request vector, pointer; output: winner index, valid).
REQ-033 A burst-length-to-beat-count function SHALL be provided in AHB_package.

Verification
REQ-034 Reset, then hreq=4'b1111 held with SINGLE NONSEQ and hready=1 -> grant order 1,2,3,0,1; hmaster_data lags hmaster_addr by 1 cycle.
REQ-035 Master 2 starts INCR8 while hreq=4'b1111 -> hgrant=4'b0100 for exactly 8 address phases, then moves to master 3.
REQ-036 INCR4 with hready=0 for 3 cycles on beat 2 -> grant, counter and hmaster_data frozen; burst ends after 4 completed beats.
REQ-037 Master 1 hlock=1 for 5 transfers while others request -> hmastlock=1 and hgrant=4'b0010 throughout; release only after hlock=0 with hready=1.
REQ-038 hreset=1 asserted on beat 5 of an INCR16 -> next cycle hgrant=4'b0001, FSM=IDLE, hmastlock=0, hmaster_data=0.
REQ-039 Owner drives IDLE on beat 2 of WRAP8 -> FSM returns to IDLE, re-arbitration at that edge.
